dr_adder_n_clk: RTL and testbench
=================================

// Module: dr_adder_n_clk
// PURPOSE
// - Clocked WIDTH-bit dual-rail adder: accepts dual-rail operand tokens a, b, c_in; emits dual-rail s, c_out.
// - Supports both team encodings: "FP" (four-phase, return-to-zero) and "TP" (two-phase, toggle).
// - Per-pair completion detection; FSM-sequenced handshake with the upstream driver (in_ack) and downstream monitor (out_ack).
// - Next-generation replacement for the single-bit toggle full adder; drops between async dual-rail stages and clocked logic.
// PARAMETERS
// - ENC    "TP"  encoding: "TP" = toggle/two-phase, "FP" = four-phase RTZ.
// - WIDTH  4     operand width in bits (>=1).
// PORTS
// - clk      in   1          clock; all state rising-edge.
// - rst      in   1          asynchronous, active-high reset.
// - a        in   [WIDTH][2] operand A, one rail pair per bit; [1]=true rail, [0]=false rail.
// - b        in   [WIDTH][2] operand B, same format.
// - c_in     in   [2]        carry-in rail pair.
// - out_ack  in   1          downstream acknowledge (FP: level; TP: toggle).
// - s        out  [WIDTH][2] sum rail pairs.
// - c_out    out  [2]        carry-out rail pair.
// - in_ack   out  1          upstream acknowledge (FP: level; TP: toggle).
// - err      out  1          sticky illegal-code flag.
// BEHAVIOUR
// - Reset (async): s, c_out = 2'b00 per pair; in_ack = 0; err = 0; FSM = IDLE; TP reference registers = 0.
// - FP codes: 00 NULL, 01 logic 0, 10 logic 1, 11 illegal.
// - TP: a pair is complete when it differs from its reference in exactly one rail; rail[0] toggled = 0, rail[1] toggled = 1. Both rails toggled = illegal.
// - FSM IDLE: wait until every pair of a, b, c_in is complete (FP: all non-NULL). Partial inputs: hold, no timeout.
//   - On the completion cycle n, compute {c_out,s} = a + b + c_in (WIDTH+1 bits, no overflow lost); outputs registered at edge n+1; go OUT.
//   - FP: write the value code into s/c_out. TP: toggle the rail matching each result bit.
// - FSM OUT: hold outputs.
//   - FP: on out_ack == 1 -> in_ack = 1, go RTZ.
//   - TP: on out_ack != out_ack_ref -> toggle in_ack, latch input rails into the references, update out_ack_ref, go IDLE.
// - FSM RTZ (FP only): wait until all input pairs == NULL and out_ack == 1.
//   - Then drive s/c_out = NULL and wait for out_ack == 0.
//   - Then in_ack = 0, go IDLE.
// - Illegal code on any input pair, in any state: err = 1 on the next edge. FSM freezes and outputs hold until rst.
// - Simultaneous completion and illegal code on the same cycle: the error wins; no output token is issued.
// - Input changes while in OUT (protocol violation) are ignored. Only the illegal-code check stays live.
// - Reset mid-operation: immediate return to reset values; any in-flight token is discarded.
// CONFIGURATION
// - DR_ADDER_INPUT_SYNC_EN defined:
//   - 2-flop synchronisers on every input rail and on out_ack (reset value 0).
//   - Completion/ack detection runs on synchronised copies; +2 cycles latency on each handshake leg.
// - Undefined: inputs sampled directly; they must be synchronous to clk.
// STRUCTURE
// - Package dr_pkg:
//   - typedef logic [1:0] rail_t.
//   - Constants DR_NULL = 2'b00, DR_F = 2'b01, DR_T = 2'b10, DR_ILL = 2'b11.
//   - typedef enum {IDLE, OUT, RTZ} dr_add_state_e.
// - Sub-module dr_pair_decode #(ENC): inputs pair + reference; outputs complete, value, illegal.
//   - Instantiated 2*WIDTH+1 times.
// - Top: FSM, adder, output/reference registers, optional synchronisers.
// TESTING
// - Reset: rst=1 with random inputs -> s all 2'b00, c_out 2'b00, in_ack 0, err 0.
// - FP, WIDTH=4: a=5, b=3, c_in=0.
//   - Expect s=8 (pairs 10,01,01,01 MSB->LSB), c_out=01, one cycle after the last input completes.
//   - out_ack=1 -> in_ack=1. Inputs NULL -> s NULL. out_ack=0 -> in_ack=0.
// - TP, WIDTH=4: a=15, b=1, c_in=1.
//   - Expect s=1 (rail[1] toggled only on bit0, rail[0] toggled on bits 3..1) and c_out rail[1] toggled.
//   - out_ack toggle -> in_ack toggles; a second token is then accepted.
// - Partial: a, b complete, c_in held NULL for 20 cycles -> outputs unchanged. c_in=10 -> result on the next edge.
// - Illegal: FP a[2]=2'b11 -> err=1 on the next edge, no output token; stays frozen until rst.
// - Reset in OUT: assert rst mid-cycle -> outputs NULL and in_ack=0 without a clock edge; the next token is processed normally.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared types and rail codes for the dual-rail adder.
// Pair layout: [1] = true rail, [0] = false rail.
package dr_pkg;

    typedef logic [1:0] rail_t;

    localparam rail_t DR_NULL = 2'b00;
    localparam rail_t DR_F    = 2'b01;
    localparam rail_t DR_T    = 2'b10;
    localparam rail_t DR_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, OUT, RTZ} dr_add_state_e;

    // Value code for one bit. It doubles as the TP toggle mask for that bit.
    function automatic rail_t dr_code(input logic v);
        return v ? DR_T : DR_F;
    endfunction

endpackage

// File: rtl/dr_pair_decode.sv
// Completion/value/illegal decode for one dual-rail pair.
// FP looks at the raw code; TP looks at which rails moved relative to the reference.
module dr_pair_decode
    import dr_pkg::*;
#(
    parameter string ENC = "TP"
) (
    input  rail_t pair_i,
    input  rail_t ref_i,
    output logic  complete_o,
    output logic  value_o,
    output logic  illegal_o
);

    localparam bit IsTp = (ENC == "TP");

    rail_t diff;

    // Once the toggle set is formed, TP decodes exactly like an FP code.
    assign diff       = IsTp ? (pair_i ^ ref_i) : pair_i;
    assign complete_o = (diff == DR_F) || (diff == DR_T);
    assign value_o    = diff[1];
    assign illegal_o  = (diff == DR_ILL);

endmodule

// File: rtl/dr_adder_n_clk.sv
// Clocked WIDTH-bit dual-rail adder with FP (RTZ) or TP (toggle) handshake.
// Define DR_ADDER_INPUT_SYNC_EN to add 2-flop synchronisers on every input rail and out_ack.
module dr_adder_n_clk
    import dr_pkg::*;
#(
    parameter string       ENC   = "TP",
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0][1:0]  a,
    input  logic [WIDTH-1:0][1:0]  b,
    input  logic [1:0]             c_in,
    input  logic                   out_ack,
    output logic [WIDTH-1:0][1:0]  s,
    output logic [1:0]             c_out,
    output logic                   in_ack,
    output logic                   err
);

    localparam bit IsTp = (ENC == "TP");

    logic [WIDTH-1:0][1:0] a_in, b_in;
    rail_t                 c_in_s;
    logic                  ack_in;

`ifdef DR_ADDER_INPUT_SYNC_EN
    localparam int unsigned SyncW = 4 * WIDTH + 3;
    logic [SyncW-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {a, b, c_in, out_ack};
            sync2_q <= sync1_q;
        end
    end

    assign {a_in, b_in, c_in_s, ack_in} = sync2_q;
`else
    assign a_in   = a;
    assign b_in   = b;
    assign c_in_s = c_in;
    assign ack_in = out_ack;
`endif

    dr_add_state_e         state_q, state_d;
    logic [WIDTH-1:0][1:0] s_q, s_d;
    rail_t                 cout_q, cout_d;
    logic                  in_ack_q, in_ack_d;
    logic                  err_q, err_d;
    logic                  rtz_null_q, rtz_null_d;
    logic [WIDTH-1:0][1:0] a_ref_q, a_ref_d, b_ref_q, b_ref_d;
    rail_t                 c_ref_q, c_ref_d;
    logic                  ack_ref_q, ack_ref_d;

    logic [WIDTH-1:0] a_cmp, a_val, a_ill, b_cmp, b_val, b_ill;
    logic             c_cmp, c_val, c_ill;

    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        dr_pair_decode #(.ENC(ENC)) u_a (
            .pair_i     (a_in[i]),
            .ref_i      (a_ref_q[i]),
            .complete_o (a_cmp[i]),
            .value_o    (a_val[i]),
            .illegal_o  (a_ill[i])
        );
        dr_pair_decode #(.ENC(ENC)) u_b (
            .pair_i     (b_in[i]),
            .ref_i      (b_ref_q[i]),
            .complete_o (b_cmp[i]),
            .value_o    (b_val[i]),
            .illegal_o  (b_ill[i])
        );
    end

    dr_pair_decode #(.ENC(ENC)) u_c (
        .pair_i     (c_in_s),
        .ref_i      (c_ref_q),
        .complete_o (c_cmp),
        .value_o    (c_val),
        .illegal_o  (c_ill)
    );

    logic           all_cmp, any_ill, all_null;
    logic [WIDTH:0] sum;

    assign all_cmp  = (&a_cmp) && (&b_cmp) && c_cmp;
    assign any_ill  = (|a_ill) || (|b_ill) || c_ill;
    assign all_null = (a_in == '0) && (b_in == '0) && (c_in_s == DR_NULL);
    assign sum      = {1'b0, a_val} + {1'b0, b_val} + {{WIDTH{1'b0}}, c_val};

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        cout_d     = cout_q;
        in_ack_d   = in_ack_q;
        err_d      = err_q;
        rtz_null_d = rtz_null_q;
        a_ref_d    = a_ref_q;
        b_ref_d    = b_ref_q;
        c_ref_d    = c_ref_q;
        ack_ref_d  = ack_ref_q;

        // A latched error freezes everything; an illegal code beats a same-cycle completion.
        if (err_q) begin
            err_d = 1'b1;
        end else if (any_ill) begin
            err_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (all_cmp) begin
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            s_d[i] = IsTp ? (s_q[i] ^ dr_code(sum[i])) : dr_code(sum[i]);
                        end
                        cout_d  = IsTp ? (cout_q ^ dr_code(sum[WIDTH])) : dr_code(sum[WIDTH]);
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (IsTp) begin
                        if (ack_in != ack_ref_q) begin
                            in_ack_d  = ~in_ack_q;
                            a_ref_d   = a_in;
                            b_ref_d   = b_in;
                            c_ref_d   = c_in_s;
                            ack_ref_d = ack_in;
                            state_d   = IDLE;
                        end
                    end else if (ack_in) begin
                        in_ack_d   = 1'b1;
                        rtz_null_d = 1'b0;
                        state_d    = RTZ;
                    end
                end
                RTZ: begin
                    // Two legs: outputs return to NULL first, then wait for ack to drop.
                    if (!rtz_null_q) begin
                        if (all_null && ack_in) begin
                            s_d        = '0;
                            cout_d     = DR_NULL;
                            rtz_null_d = 1'b1;
                        end
                    end else if (!ack_in) begin
                        in_ack_d   = 1'b0;
                        rtz_null_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            cout_q     <= DR_NULL;
            in_ack_q   <= 1'b0;
            err_q      <= 1'b0;
            rtz_null_q <= 1'b0;
            a_ref_q    <= '0;
            b_ref_q    <= '0;
            c_ref_q    <= DR_NULL;
            ack_ref_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            cout_q     <= cout_d;
            in_ack_q   <= in_ack_d;
            err_q      <= err_d;
            rtz_null_q <= rtz_null_d;
            a_ref_q    <= a_ref_d;
            b_ref_q    <= b_ref_d;
            c_ref_q    <= c_ref_d;
            ack_ref_q  <= ack_ref_d;
        end
    end

    assign s      = s_q;
    assign c_out  = cout_q;
    assign in_ack = in_ack_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dr_adder_n_clk.sv
// Bench for dr_adder_n_clk: one FP and one TP instance, per-cycle compare against
// expected outputs derived from plain arithmetic, plus literal spot checks.
module tb_dr_adder_n_clk;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [W-1:0][1:0] fa, fb, fs, ta, tb, ts;
    logic [1:0]        fc, fco, tc, tco;
    logic              fack, fia, ferr, tack, tia, terr;

    logic [W-1:0][1:0] exp_fs, exp_ts;
    logic [1:0]        exp_fc, exp_tc;
    logic              exp_fia, exp_ferr, exp_tia, exp_terr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dr_adder_n_clk #(.ENC("FP"), .WIDTH(W)) dut_fp (
        .clk     (clk),
        .rst     (rst),
        .a       (fa),
        .b       (fb),
        .c_in    (fc),
        .out_ack (fack),
        .s       (fs),
        .c_out   (fco),
        .in_ack  (fia),
        .err     (ferr)
    );

    dr_adder_n_clk #(.ENC("TP"), .WIDTH(W)) dut_tp (
        .clk     (clk),
        .rst     (rst),
        .a       (ta),
        .b       (tb),
        .c_in    (tc),
        .out_ack (tack),
        .s       (ts),
        .c_out   (tco),
        .in_ack  (tia),
        .err     (terr)
    );

    // Value code per bit (01 = 0, 10 = 1); also the TP toggle mask for that value.
    function automatic logic [2*W-1:0] code(input int v);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) r[2*i+:2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [1:0] bit_code(input int v);
        return (v != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("fp_s",      32'(fs),   32'(exp_fs));
        chk("fp_c_out",  32'(fco),  32'(exp_fc));
        chk("fp_in_ack", 32'(fia),  32'(exp_fia));
        chk("fp_err",    32'(ferr), 32'(exp_ferr));
        chk("tp_s",      32'(ts),   32'(exp_ts));
        chk("tp_c_out",  32'(tco),  32'(exp_tc));
        chk("tp_in_ack", 32'(tia),  32'(exp_tia));
        chk("tp_err",    32'(terr), 32'(exp_terr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        fa = '0; fb = '0; fc = '0; fack = 1'b0;
        ta = '0; tb = '0; tc = '0; tack = 1'b0;
        exp_fs = '0; exp_fc = '0; exp_fia = 1'b0; exp_ferr = 1'b0;
        exp_ts = '0; exp_tc = '0; exp_tia = 1'b0; exp_terr = 1'b0;
    endtask

    task automatic fp_issue(input int av, input int bv, input int cv);
        int sum;
        sum = av + bv + cv;
        fa = code(av); fb = code(bv); fc = bit_code(cv);
        step();
        exp_fs = code(sum);
        exp_fc = bit_code((sum >> W) & 1);
    endtask

    task automatic fp_finish();
        fack = 1'b1;
        step();
        exp_fia = 1'b1;
        fa = '0; fb = '0; fc = '0;
        step();
        exp_fs = '0;
        exp_fc = '0;
        fack = 1'b0;
        step();
        exp_fia = 1'b0;
    endtask

    task automatic tp_issue(input int av, input int bv, input int cv);
        int sum;
        sum = av + bv + cv;
        ta = ta ^ code(av); tb = tb ^ code(bv); tc = tc ^ bit_code(cv);
        step();
        exp_ts = exp_ts ^ code(sum);
        exp_tc = exp_tc ^ bit_code((sum >> W) & 1);
    endtask

    task automatic tp_ack();
        tack = ~tack;
        step();
        exp_tia = ~exp_tia;
    endtask

    initial begin
        clear_all();
        fa = 8'($urandom); fb = 8'($urandom); fc = 2'($urandom); fack = 1'($urandom);
        ta = 8'($urandom); tb = 8'($urandom); tc = 2'($urandom); tack = 1'($urandom);
        #1 rst = 1'b1;
        repeat (3) step();
        chk("rst_fp_s",   32'(fs),   32'h0);
        chk("rst_fp_c",   32'(fco),  32'h0);
        chk("rst_fp_ack", 32'(fia),  32'h0);
        chk("rst_fp_err", 32'(ferr), 32'h0);
        chk("rst_tp_s",   32'(ts),   32'h0);
        chk("rst_tp_ack", 32'(tia),  32'h0);
        clear_all();
        step();
        rst = 1'b0;
        step();

        // FP 5 + 3 + 0 = 8
        fp_issue(5, 3, 0);
        chk("fp_5p3_s", 32'(fs),  32'h95);
        chk("fp_5p3_c", 32'(fco), 32'h1);
        fp_finish();

        // Partial: carry-in held NULL, then 2 + 4 + 1 = 7
        fa = code(2); fb = code(4); fc = 2'b00;
        repeat (20) step();
        chk("partial_hold", 32'(fs), 32'h0);
        fc = 2'b10;
        step();
        exp_fs = code(7);
        exp_fc = 2'b01;
        chk("partial_s", 32'(fs), 32'h6A);
        fp_finish();

        // Widest sum: 15 + 15 + 1 = 31
        fp_issue(15, 15, 1);
        chk("fp_max_s", 32'(fs),  32'hAA);
        chk("fp_max_c", 32'(fco), 32'h2);
        fp_finish();

        // Reset while in OUT, mid-cycle
        fp_issue(1, 1, 0);
        #3;
        rst = 1'b1;
        clear_all();
        #1;
        chk("rst_out_s",   32'(fs),  32'h0);
        chk("rst_out_ack", 32'(fia), 32'h0);
        step();
        rst = 1'b0;
        step();
        fp_issue(2, 2, 1);
        fp_finish();

        // TP 15 + 1 + 1 = 17
        tp_issue(15, 1, 1);
        chk("tp_17_s", 32'(ts),  32'h56);
        chk("tp_17_c", 32'(tco), 32'h2);
        tp_ack();
        tp_issue(6, 9, 0);
        chk("tp_15_s", 32'(ts),  32'hFC);
        chk("tp_15_c", 32'(tco), 32'h3);
        tp_ack();
        tp_issue(8, 8, 0);
        tp_ack();

        // TP illegal: both carry-in rails toggle
        tc = tc ^ 2'b11;
        step();
        exp_terr = 1'b1;
        repeat (3) step();

        // FP illegal on a[2] with everything else complete: error wins, then frozen
        fa = code(5);
        fa[2] = 2'b11;
        fb = code(3); fc = 2'b01;
        step();
        exp_ferr = 1'b1;
        chk("fp_ill_err", 32'(ferr), 32'h1);
        fa = code(5);
        fack = 1'b1;
        repeat (5) step();
        chk("fp_frozen_s", 32'(fs), 32'h0);

        // Reset clears the freeze; both encodings work again
        rst = 1'b1;
        clear_all();
        step();
        rst = 1'b0;
        step();
        fp_issue(3, 4, 0);
        fp_finish();
        tp_issue(1, 2, 0);
        tp_ack();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
